// File: rtl/period_meter.sv
// period_meter: recovers the period and high time of a slow periodic input,
// both counted in cycles of clk. The input is synchronised, its edges are
// detected, and a counter running between consecutive rising edges is
// captured into registered outputs together with a one-cycle valid strobe.
module period_meter #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             timeout,
    output logic             busy
);

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sigSync_q;
    logic                   sigPrev_q;
    logic                   sigNow;
    logic                   rise;
    logic                   fall;

    state_t                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic [CNT_W-1:0]       highCap_q;
    logic [CNT_W-1:0]       period_q;
    logic [CNT_W-1:0]       highTime_q;
    logic                   valid_q;
    logic                   timeout_q;
    logic                   busy_q;

    // Shift the asynchronous input through the synchroniser chain and keep
    // the previous synchronised value for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sigSync_q <= '0;
            sigPrev_q <= 1'b0;
        end else begin
            sigSync_q <= {sigSync_q[SYNC_STAGES-2:0], sig_in};
            sigPrev_q <= sigSync_q[SYNC_STAGES-1];
        end
    end

    assign sigNow = sigSync_q[SYNC_STAGES-1];
    assign rise   = sigNow & ~sigPrev_q;
    assign fall   = ~sigNow & sigPrev_q;
    assign cnt_d  = cnt_q + CNT_ONE;

    // Measurement FSM: the first rise arms the counter, each later rise
    // publishes the count; saturation without a rise aborts to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            highCap_q  <= '0;
            period_q   <= '0;
            highTime_q <= '0;
            valid_q    <= 1'b0;
            timeout_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            if (!en) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        cnt_q  <= '0;
                        busy_q <= 1'b0;
                        if (rise) begin
                            cnt_q   <= CNT_ONE;
                            state_q <= MEASURE;
                            busy_q  <= 1'b1;
                        end
                    end
                    MEASURE: begin
                        busy_q <= 1'b1;
                        if (fall) begin
                            highCap_q <= cnt_q;
                        end
                        if (rise) begin
                            period_q   <= cnt_q;
                            highTime_q <= highCap_q;
                            valid_q    <= 1'b1;
                            cnt_q      <= CNT_ONE;
                        end else if (cnt_q == CNT_MAX) begin
                            timeout_q <= 1'b1;
                            cnt_q     <= '0;
                            state_q   <= IDLE;
                            busy_q    <= 1'b0;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign period    = period_q;
    assign high_time = highTime_q;
    assign valid     = valid_q;
    assign timeout   = timeout_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter: directed scenarios for period_meter with CNT_W=8 so the
// counter saturation case is reachable in a few hundred cycles.
module tb_period_meter;

    localparam int CNT_W = 8;
    localparam int SYNC  = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             sigIn;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] highTime;
    logic             valid;
    logic             timeout;
    logic             busy;

    int checks = 0;
    int errors = 0;
    int cycleCount = 0;
    int timeoutCount = 0;
    int timeoutStamp = 0;
    int valPeriod[$];
    int valHigh[$];
    int valStamp[$];

    period_meter #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .sig_in    (sigIn),
        .period    (period),
        .high_time (highTime),
        .valid     (valid),
        .timeout   (timeout),
        .busy      (busy)
    );

    // Free-running clock and a cycle stamp that advances on each rising edge.
    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    // Record every valid strobe and timeout pulse on the falling edge.
    always @(negedge clk) begin
        if (valid === 1'b1) begin
            valPeriod.push_back(int'(period));
            valHigh.push_back(int'(highTime));
            valStamp.push_back(cycleCount);
        end
        if (timeout === 1'b1) begin
            timeoutCount = timeoutCount + 1;
            timeoutStamp = cycleCount;
        end
    end

    // Hard stop in case a scenario never returns.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance n clock cycles, landing 2 time units after a rising edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Square wave: hi cycles high then lo cycles low, repeated n times.
    task automatic drive(input int hi, input int lo, input int n);
        for (int p = 0; p < n; p++) begin
            sigIn = 1'b1;
            tick(hi);
            sigIn = 1'b0;
            tick(lo);
        end
    endtask

    // Behavioural counter-based divider: output high for ratio/2 cycles.
    task automatic divRun(input int ratio, input int n);
        for (int p = 0; p < n; p++) begin
            for (int c = 0; c < ratio; c++) begin
                sigIn = (c < ratio / 2);
                tick(1);
            end
        end
    endtask

    task automatic applyReset();
        rst   = 1'b1;
        sigIn = 1'b0;
        en    = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(1);
        valPeriod.delete();
        valHigh.delete();
        valStamp.delete();
        timeoutCount = 0;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        en    = 1'b0;
        sigIn = 1'b0;
        #1;
        checks++; if (period !== 8'd0) begin errors++; $display("[TB] FAIL reset_period: got %0d expected 0", period); end
        checks++; if (highTime !== 8'd0) begin errors++; $display("[TB] FAIL reset_high: got %0d expected 0", highTime); end
        checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", valid); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("[TB] FAIL reset_timeout: got %b expected 0", timeout); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        tick(2);
        rst = 1'b0;
        en  = 1'b1;
        tick(3);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_symmetric();
        int r0;
        applyReset();
        r0 = cycleCount;
        drive(5, 5, 6);
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL sym_busy: got %b expected 1", busy); end
        tick(4);
        checks++; if (valPeriod.size() != 5) begin errors++; $display("[TB] FAIL sym_count: got %0d expected 5", valPeriod.size()); end
        if (valStamp.size() > 0) begin
            checks++; if (valStamp[0] != r0 + 13) begin errors++; $display("[TB] FAIL sym_first_latency: got %0d expected %0d", valStamp[0], r0 + 13); end
        end
        for (int i = 0; i < 5 && i < valPeriod.size(); i++) begin
            checks++; if (valPeriod[i] != 10) begin errors++; $display("[TB] FAIL sym_period[%0d]: got %0d expected 10", i, valPeriod[i]); end
            checks++; if (valHigh[i] != 5) begin errors++; $display("[TB] FAIL sym_high[%0d]: got %0d expected 5", i, valHigh[i]); end
            if (i > 0) begin
                checks++; if (valStamp[i] - valStamp[i-1] != 10) begin errors++; $display("[TB] FAIL sym_spacing[%0d]: got %0d expected 10", i, valStamp[i] - valStamp[i-1]); end
            end
        end
    endtask

    task automatic test_asymmetric();
        int expP;
        int expH;
        applyReset();
        drive(3, 7, 4);
        drive(1, 1, 6);
        tick(4);
        checks++; if (valPeriod.size() != 9) begin errors++; $display("[TB] FAIL asym_count: got %0d expected 9", valPeriod.size()); end
        for (int i = 0; i < 9 && i < valPeriod.size(); i++) begin
            expP = (i < 4) ? 10 : 2;
            expH = (i < 4) ? 3 : 1;
            checks++; if (valPeriod[i] != expP) begin errors++; $display("[TB] FAIL asym_period[%0d]: got %0d expected %0d", i, valPeriod[i], expP); end
            checks++; if (valHigh[i] != expH) begin errors++; $display("[TB] FAIL asym_high[%0d]: got %0d expected %0d", i, valHigh[i], expH); end
        end
    endtask

    task automatic test_timeout();
        applyReset();
        drive(5, 5, 3);
        tick(260);
        checks++; if (timeoutCount != 1) begin errors++; $display("[TB] FAIL to_count: got %0d expected 1", timeoutCount); end
        checks++; if (valPeriod.size() != 2) begin errors++; $display("[TB] FAIL to_valids: got %0d expected 2", valPeriod.size()); end
        if (valStamp.size() == 2) begin
            checks++; if (timeoutStamp - valStamp[1] != 255) begin errors++; $display("[TB] FAIL to_delay: got %0d expected 255", timeoutStamp - valStamp[1]); end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL to_busy: got %b expected 0", busy); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("[TB] FAIL to_pulse_width: got %b expected 0", timeout); end
        checks++; if (period !== 8'd10) begin errors++; $display("[TB] FAIL to_period_hold: got %0d expected 10", period); end
        checks++; if (highTime !== 8'd5) begin errors++; $display("[TB] FAIL to_high_hold: got %0d expected 5", highTime); end
        drive(5, 5, 1);
        tick(3);
        checks++; if (valPeriod.size() != 2) begin errors++; $display("[TB] FAIL to_rearm_novalid: got %0d expected 2", valPeriod.size()); end
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL to_rearm_busy: got %b expected 1", busy); end
    endtask

    task automatic test_enable_gap();
        int nBefore;
        applyReset();
        drive(5, 5, 2);
        sigIn = 1'b1;
        tick(5);
        sigIn = 1'b0;
        tick(2);
        en = 1'b0;
        tick(1);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL gap_busy: got %b expected 0", busy); end
        nBefore = valPeriod.size();
        checks++; if (nBefore != 2) begin errors++; $display("[TB] FAIL gap_pre_count: got %0d expected 2", nBefore); end
        tick(3);
        en = 1'b1;
        tick(4);
        checks++; if (valPeriod.size() != nBefore) begin errors++; $display("[TB] FAIL gap_novalid: got %0d expected %0d", valPeriod.size(), nBefore); end
        drive(5, 5, 3);
        tick(4);
        checks++; if (valPeriod.size() != 4) begin errors++; $display("[TB] FAIL gap_count: got %0d expected 4", valPeriod.size()); end
        for (int i = 0; i < 4 && i < valPeriod.size(); i++) begin
            checks++; if (valPeriod[i] != 10) begin errors++; $display("[TB] FAIL gap_period[%0d]: got %0d expected 10", i, valPeriod[i]); end
            checks++; if (valHigh[i] != 5) begin errors++; $display("[TB] FAIL gap_high[%0d]: got %0d expected 5", i, valHigh[i]); end
        end
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL gap_busy_after: got %b expected 1", busy); end
    endtask

    task automatic test_async_reset();
        int r1;
        applyReset();
        drive(5, 5, 2);
        sigIn = 1'b1;
        tick(3);
        checks++; if (period !== 8'd10) begin errors++; $display("[TB] FAIL ar_pre_period: got %0d expected 10", period); end
        #1;
        rst = 1'b1;
        #1;
        checks++; if (period !== 8'd0) begin errors++; $display("[TB] FAIL ar_period: got %0d expected 0", period); end
        checks++; if (highTime !== 8'd0) begin errors++; $display("[TB] FAIL ar_high: got %0d expected 0", highTime); end
        checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL ar_valid: got %b expected 0", valid); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("[TB] FAIL ar_timeout: got %b expected 0", timeout); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL ar_busy: got %b expected 0", busy); end
        sigIn = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(2);
        valPeriod.delete();
        valHigh.delete();
        valStamp.delete();
        r1 = cycleCount;
        drive(5, 5, 3);
        tick(4);
        checks++; if (valPeriod.size() != 2) begin errors++; $display("[TB] FAIL ar_count: got %0d expected 2", valPeriod.size()); end
        if (valStamp.size() > 0) begin
            checks++; if (valStamp[0] != r1 + 13) begin errors++; $display("[TB] FAIL ar_first_latency: got %0d expected %0d", valStamp[0], r1 + 13); end
            checks++; if (valPeriod[0] != 10 || valHigh[0] != 5) begin errors++; $display("[TB] FAIL ar_first_value: got %0d/%0d expected 10/5", valPeriod[0], valHigh[0]); end
        end
    endtask

    task automatic test_divider();
        int expP;
        int expH;
        applyReset();
        divRun(6, 4);
        divRun(7, 4);
        tick(4);
        checks++; if (valPeriod.size() != 7) begin errors++; $display("[TB] FAIL div_count: got %0d expected 7", valPeriod.size()); end
        for (int i = 0; i < 7 && i < valPeriod.size(); i++) begin
            expP = (i < 4) ? 6 : 7;
            expH = 3;
            checks++; if (valPeriod[i] != expP) begin errors++; $display("[TB] FAIL div_period[%0d]: got %0d expected %0d", i, valPeriod[i], expP); end
            checks++; if (valHigh[i] != expH) begin errors++; $display("[TB] FAIL div_high[%0d]: got %0d expected %0d", i, valHigh[i], expH); end
        end
    endtask

    // Run every scenario in order, then report.
    initial begin
        test_reset();
        test_symmetric();
        test_asymmetric();
        test_timeout();
        test_enable_gap();
        test_async_reset();
        test_divider();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
